// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts a command byte
// out on device-generated clocks and captures the device acknowledge. Open-drain outputs.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int REQ_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err_timeout
);

   localparam int MAX_IR = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int MAX_C  = (TIMEOUT_CYCLES > MAX_IR) ? TIMEOUT_CYCLES : MAX_IR;
   localparam int CW     = $clog2(MAX_C + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      SEND      = 3'd3,
      WAIT_ACK  = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      bit_q, bit_d;
   logic [7:0]      data_q, data_d;
   logic            ack_q, ack_d;

   logic            clk_s1_q, clk_s2_q, clk_prev_q;
   logic            data_s1_q, data_s2_q;
   logic            fall;
   logic            frame_bit;
   logic [3:0]      bit_m1;
   logic            in_frame;

   // Lines idle high, so the synchronisers reset to 1 to avoid a phantom falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         ack_q      <= 1'b0;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         ack_q      <= ack_d;
         clk_s1_q   <= ps2_clk_i;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         data_s1_q  <= ps2_data_i;
         data_s2_q  <= data_s1_q;
      end
   end

   assign fall = ~clk_s2_q & clk_prev_q;

   // Frame position 0 is the start bit, 1..8 data LSB first, 9 odd parity, 10 stop.
   always_comb begin
      bit_m1    = bit_q - 4'd1;
      frame_bit = 1'b1;
      if (bit_q == 4'd0) begin
         frame_bit = 1'b0;
      end else if (bit_q <= 4'd8) begin
         frame_bit = data_q[bit_m1[2:0]];
      end else if (bit_q == 4'd9) begin
         frame_bit = ~^data_q;
      end
   end

   assign in_frame = (state_q == SEND) || (state_q == WAIT_ACK) || (state_q == WAIT_IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      data_d      = data_q;
      ack_d       = ack_q;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      done        = 1'b0;
      err_timeout = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (tx_valid) begin
               data_d  = tx_data;
               ack_d   = 1'b0;
               state_d = INHIBIT;
            end
         end
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = REQ;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         REQ: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = 1'b1;
            if (cnt_q == CW'(REQ_CYCLES - 1)) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = SEND;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SEND: begin
            ps2_data_oe = ~frame_bit;
            if (fall) begin
               bit_d = bit_q + 4'd1;
               if (bit_q == 4'd9) begin
                  state_d = WAIT_ACK;
               end
            end
         end
         WAIT_ACK: begin
            if (fall) begin
               ack_d   = ~data_s2_q;
               bit_d   = 4'd11;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (clk_s2_q && data_s2_q) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Timeout only aborts when the frame is not finishing this same cycle.
      if (in_frame) begin
         if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
            if (!done) begin
               err_timeout = 1'b1;
               state_d     = IDLE;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign ack_ok   = done & ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the sampled bits, handshake timing and abort paths are compared to hand-computed values.
module tb_ps2_host_tx;

   localparam int INH = 40;
   localparam int RQ  = 16;
   localparam int TO  = 3000;
   localparam int HP  = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       busy, done, ack_ok, err_timeout;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_line, ps2_data_line;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cnt  = 0;
   int err_cnt  = 0;
   int both_cnt = 0;
   int busy_gap = 0;

   logic [10:0] exp_q[$];

   assign ps2_clk_line  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .REQ_CYCLES    (RQ),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .ps2_clk_i  (ps2_clk_line),
      .ps2_data_i (ps2_data_line),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .ack_ok     (ack_ok),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Cycle counter and event tallies, taken on the edge the DUT itself samples.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (tx_valid && tx_ready) acc_cnt = acc_cnt + 1;
      if (err_timeout) err_cnt = err_cnt + 1;
      if (done && err_timeout) both_cnt = both_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      tx_data  = b;
      tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Device model: samples the wire on every rising clock line, start bit on the release.
   task automatic device_frame(input bit do_ack, input int abort_at, output logic [10:0] bits);
      int n;
      bits = '0;
      n = 0;
      while (!ps2_clk_oe && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("dev_req_seen", ps2_clk_oe, 1);
      n = 0;
      while (ps2_clk_oe && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("dev_clk_released", ps2_clk_oe, 0);
      bits[0] = ps2_data_line;
      repeat (HP) @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         dev_clk = 1'b0;
         repeat (HP) @(negedge clk);
         if (k == abort_at) return;
         dev_clk = 1'b1;
         bits[k] = ps2_data_line;
         if (!busy) busy_gap++;
         repeat (HP) @(negedge clk);
      end
      if (do_ack) dev_data = 1'b0;
      repeat (4) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HP) @(negedge clk);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
   endtask

   task automatic wait_done(input string tag, input logic exp_ack);
      int n;
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_ack_ok"}, ack_ok, exp_ack);
   endtask

   task automatic measure_req(output int hi_len, output int data_dly, output int fall_at);
      int n, r;
      n = 0;
      while (!ps2_clk_oe && n < 2000) begin
         @(negedge clk);
         n++;
      end
      r = cyc;
      n = 0;
      while (!ps2_data_oe && n < 2000) begin
         @(negedge clk);
         n++;
      end
      data_dly = cyc - r;
      n = 0;
      while (ps2_clk_oe && n < 2000) begin
         @(negedge clk);
         n++;
      end
      fall_at = cyc;
      hi_len  = cyc - r;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] bits, bits2;
      int hi_len, data_dly, fall_at, d1, r2, e_at, acc_before, n;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_tx_ready", tx_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_clk_oe", ps2_clk_oe, 0);
      check_eq("rst_data_oe", ps2_data_oe, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ack_ok", ack_ok, 0);
      check_eq("rst_err", err_timeout, 0);

      // 0xED with ACK: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
      exp_q.push_back(11'h7DA);
      fork
         send_byte(8'hED);
         device_frame(1'b1, 0, bits);
         measure_req(hi_len, data_dly, fall_at);
      join
      wait_done("ed", 1'b1);
      check_eq("ed_bits", bits, exp_q.pop_front());
      check_eq("ed_clk_oe_len", hi_len, INH + RQ);
      check_eq("ed_data_oe_delay", data_dly, INH);
      check_eq("ed_busy_gap", busy_gap, 0);
      repeat (10) @(negedge clk);

      // 0x01 then 0x00 back-to-back with tx_valid held
      exp_q.push_back(11'h402);
      exp_q.push_back(11'h600);
      fork
         begin
            tx_data  = 8'h01;
            tx_valid = 1'b1;
            n = 0;
            while (!tx_ready && n < 100) begin
               @(negedge clk);
               n++;
            end
            @(negedge clk);
            tx_data = 8'h00;
            n = 0;
            while (!tx_ready && n < 3000) begin
               @(negedge clk);
               n++;
            end
            @(negedge clk);
            tx_valid = 1'b0;
         end
         begin
            device_frame(1'b1, 0, bits);
            wait_done("b2b1", 1'b1);
            check_eq("b2b_ready_low_at_done", tx_ready, 0);
            d1 = cyc;
            n = 0;
            while (!ps2_clk_oe && n < 100) begin
               @(negedge clk);
               n++;
            end
            r2 = cyc;
            check_eq("b2b_restart_gap", r2 - d1, 2);
            device_frame(1'b1, 0, bits2);
            wait_done("b2b2", 1'b1);
         end
      join
      check_eq("b2b_bits_01", bits, exp_q.pop_front());
      check_eq("b2b_bits_00", bits2, exp_q.pop_front());
      repeat (10) @(negedge clk);

      // No ACK from the device
      exp_q.push_back(11'h7DA);
      fork
         send_byte(8'hED);
         device_frame(1'b0, 0, bits);
      join
      wait_done("nack", 1'b0);
      check_eq("nack_bits", bits, exp_q.pop_front());
      check_eq("nack_no_err", err_cnt, 0);
      repeat (10) @(negedge clk);

      // Device never clocks
      fork
         send_byte(8'hED);
         measure_req(hi_len, data_dly, fall_at);
      join
      check_eq("to_clk_oe_len", hi_len, INH + RQ);
      n = 0;
      while (!err_timeout && n < TO + 1000) begin
         @(negedge clk);
         n++;
      end
      check_eq("to_err_pulse", err_timeout, 1);
      check_eq("to_no_done", done, 0);
      e_at = cyc;
      @(negedge clk);
      check_eq("to_latency", e_at - fall_at, TO);
      check_eq("to_err_one_cycle", err_timeout, 0);
      check_eq("to_clk_oe", ps2_clk_oe, 0);
      check_eq("to_data_oe", ps2_data_oe, 0);
      check_eq("to_tx_ready", tx_ready, 1);
      repeat (10) @(negedge clk);

      // Reset while data bit 5 (0xED bit 4 = 0, line pulled) is on the wire
      fork
         send_byte(8'hED);
         device_frame(1'b1, 5, bits);
      join
      check_eq("abort_pre_data_oe", ps2_data_oe, 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_clk_oe", ps2_clk_oe, 0);
      check_eq("abort_data_oe", ps2_data_oe, 0);
      check_eq("abort_busy", busy, 0);
      rst     = 1'b0;
      dev_clk = 1'b1;
      repeat (50) @(negedge clk);
      exp_q.push_back(11'h5E8);
      fork
         send_byte(8'hF4);
         device_frame(1'b1, 0, bits);
      join
      wait_done("f4", 1'b1);
      check_eq("f4_bits", bits, exp_q.pop_front());
      repeat (10) @(negedge clk);

      // tx_valid pulsed with 0xAA mid-frame must be ignored
      acc_before = acc_cnt;
      exp_q.push_back(11'h7DA);
      fork
         send_byte(8'hED);
         device_frame(1'b1, 0, bits);
         begin
            repeat (300) @(negedge clk);
            tx_data  = 8'hAA;
            tx_valid = 1'b1;
            repeat (4) @(negedge clk);
            tx_valid = 1'b0;
         end
      join
      wait_done("ign", 1'b1);
      check_eq("ign_bits", bits, exp_q.pop_front());
      repeat (200) @(negedge clk);
      check_eq("ign_accepts", acc_cnt - acc_before, 1);
      check_eq("ign_clk_oe_idle", ps2_clk_oe, 0);
      check_eq("ign_busy_idle", busy, 0);

      check_eq("total_err_pulses", err_cnt, 1);
      check_eq("done_err_overlap", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
